// File: rtl/s2p.sv
`default_nettype none
// ============================================================================
//  Module   : s2p
//  Purpose  : Serial-to-parallel deserializer. Collects NUM serial bits on a
//             valid/ready stream and presents each completed word on a
//             parallel valid/ready interface. A shift register plus an output
//             holding register let the next word be collected while the
//             current word waits for the consumer.
//  Revision : 1.0  initial release
// ============================================================================
module s2p #(
  parameter int NUM       = 8,    // word width in bits (>= 2)
  parameter bit LSB_FIRST = 1'b1  // 1: first serial bit lands in p_data[0]
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_data,
  input  logic           s_valid,
  output logic           s_ready,
  output logic [NUM-1:0] p_data,
  output logic           p_valid,
  input  logic           p_ready
);

  localparam int             c_CW   = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(NUM - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    STALL   = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NUM-1:0]  r_shift;
  logic [NUM-1:0]  w_shift_in;
  logic [c_CW-1:0] r_cnt;
  logic [NUM-1:0]  r_p_data;
  logic            r_p_valid;
  logic            r_s_ready;
  logic            w_accept;
  logic            w_last;
  logic            w_drain;
  logic            w_load_new;
  logic            w_load_held;

  // A bit is taken only when the block advertised ready; s_ready is low in
  // STALL, so no bit can be accepted there.
  assign w_accept = s_valid && r_s_ready;
  assign w_last   = w_accept && (r_cnt == c_LAST);
  assign w_drain  = r_p_valid && p_ready;

  // Shift direction decides where the first received bit ends up.
  if (LSB_FIRST) begin : g_lsb_first
    assign w_shift_in = {s_data, r_shift[NUM-1:1]};
  end else begin : g_msb_first
    assign w_shift_in = {r_shift[NUM-2:0], s_data};
  end

  // Next-state and load decisions for the collect/stall controller.
  always_comb begin
    w_state_nxt = r_state;
    w_load_new  = 1'b0;
    w_load_held = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_last) begin
          // Output register free or emptying this edge: hand over directly.
          if (!r_p_valid || p_ready) begin
            w_load_new = 1'b1;
          end else begin
            w_state_nxt = STALL;
          end
        end
      end
      STALL: begin
        if (w_drain) begin
          w_load_held = 1'b1;
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift register, bit counter, output holding register and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_cnt     <= '0;
      r_p_data  <= '0;
      r_p_valid <= 1'b0;
      r_s_ready <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift <= w_shift_in;
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
      r_s_ready <= (w_state_nxt == COLLECT);
      if (w_load_new) begin
        r_p_data  <= w_shift_in;
        r_p_valid <= 1'b1;
      end else if (w_load_held) begin
        r_p_data  <= r_shift;
        r_p_valid <= 1'b1;
      end else if (w_drain) begin
        r_p_valid <= 1'b0;
      end
    end
  end

  assign s_ready = r_s_ready;
  assign p_data  = r_p_data;
  assign p_valid = r_p_valid;

endmodule
`default_nettype wire

// File: tb/tb_s2p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_s2p
//  Purpose  : Self-checking bench for s2p. An LSB-first instance is checked
//             through a word scoreboard plus cycle-exact directed checks; an
//             MSB-first instance is checked with directed words.
//  Revision : 1.0  initial release
// ============================================================================
module tb_s2p;

  logic       clk;
  logic       rst;
  logic       s_data, s_valid, s_ready;
  logic [7:0] p_data;
  logic       p_valid, p_ready;
  logic       s_data_m, s_valid_m, s_ready_m;
  logic [7:0] p_data_m;
  logic       p_valid_m, p_ready_m;

  int         checks;
  int         failures;
  int         n_words;
  logic [7:0] exp_q[$];

  s2p #(.NUM(8), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready)
  );

  s2p #(.NUM(8), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst),
    .s_data(s_data_m), .s_valid(s_valid_m), .s_ready(s_ready_m),
    .p_data(p_data_m), .p_valid(p_valid_m), .p_ready(p_ready_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    s_valid = 1'b1;
    s_data  = b;
    step();
  endtask

  task automatic send_word(input logic [7:0] w);
    logic [7:0] v;
    v = w;
    exp_q.push_back(v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_word_m(input logic [7:0] w);
    logic [7:0] v;
    v = w;
    for (int i = 7; i >= 0; i--) begin
      s_valid_m = 1'b1;
      s_data_m  = v[i];
      step();
      if (i != 0) check("msb_pvalid_early", p_valid_m, 1'b0);
    end
    s_valid_m = 1'b0;
    check("msb_pvalid", p_valid_m, 1'b1);
    check("msb_pdata", p_data_m, v);
  endtask

  // Scoreboard: every parallel handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && p_valid && p_ready) begin
      check("sb_nonempty", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        check("sb_word", p_data, exp_q.pop_front());
        n_words++;
      end
    end
  end

  initial begin
    logic [7:0] stream [4];
    checks = 0; failures = 0; n_words = 0;
    rst = 1'b1; s_valid = 1'b1; s_data = 1'b1; p_ready = 1'b1;
    s_valid_m = 1'b0; s_data_m = 1'b0; p_ready_m = 1'b1;

    // Reset held two cycles with s_valid high.
    step(); step();
    check("rst_pvalid", p_valid, 1'b0);
    check("rst_pdata", p_data, 8'd0);
    check("rst_sready", s_ready, 1'b0);
    rst = 1'b0;
    step();  // s_valid still high, but s_ready was low: nothing counted
    check("post_rst_sready", s_ready, 1'b1);
    s_valid = 1'b0;

    // Single word 63, LSB first, on 8 consecutive cycles.
    exp_q.push_back(8'd63);
    for (int i = 0; i < 7; i++) send_bit((8'd63 >> i) & 1'b1);
    check("single_early_pvalid", p_valid, 1'b0);
    send_bit(1'b0);
    s_valid = 1'b0;
    check("single_pvalid", p_valid, 1'b1);
    check("single_pdata", p_data, 8'd63);
    step();
    check("single_one_cycle", p_valid, 1'b0);
    check("single_count", n_words, 1);

    // Gapped word 52: three idle cycles with s_data toggling after bit 3.
    exp_q.push_back(8'd52);
    for (int i = 0; i < 4; i++) send_bit((8'd52 >> i) & 1'b1);
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_data = ~s_data;
      step();
      check("gap_pvalid", p_valid, 1'b0);
    end
    for (int i = 4; i < 8; i++) send_bit((8'd52 >> i) & 1'b1);
    s_valid = 1'b0;
    check("gap_pdata", p_data, 8'd52);
    step(); step();
    check("gap_count", n_words, 2);

    // Backpressure: 7 waits in the output register, 52 waits in STALL.
    p_ready = 1'b0;
    send_word(8'd7);
    check("bp_first_pdata", p_data, 8'd7);
    check("bp_sready_open", s_ready, 1'b1);
    send_word(8'd52);
    s_valid = 1'b0;
    check("bp_stall_sready", s_ready, 1'b0);
    check("bp_hold_pdata", p_data, 8'd7);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 1'($urandom_range(0, 1));
      step();
    end
    s_valid = 1'b0;
    check("bp_ignored_sready", s_ready, 1'b0);
    check("bp_ignored_pvalid", p_valid, 1'b1);
    check("bp_ignored_pdata", p_data, 8'd7);
    p_ready = 1'b1;
    step();
    check("bp_next_pvalid", p_valid, 1'b1);
    check("bp_next_pdata", p_data, 8'd52);
    check("bp_reopen_sready", s_ready, 1'b1);
    step();
    check("bp_drained", p_valid, 1'b0);

    // Streaming: 32 consecutive bits, one word every 8 bits.
    stream[0] = 8'd1; stream[1] = 8'd2; stream[2] = 8'd128; stream[3] = 8'd255;
    for (int w = 0; w < 4; w++) exp_q.push_back(stream[w]);
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 8; b++) begin
        send_bit(stream[w][b]);
        check("stream_sready", s_ready, 1'b1);
        check("stream_pvalid", p_valid, (b == 7));
        if (b == 7) check("stream_pdata", p_data, stream[w]);
      end
    end
    s_valid = 1'b0;
    step();

    // Mid-word reset: the partial word must vanish.
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    s_valid = 1'b0;
    rst = 1'b1;
    step();
    check("midrst_pvalid", p_valid, 1'b0);
    check("midrst_sready", s_ready, 1'b0);
    rst = 1'b0;
    step();
    check("midrst_reopen", s_ready, 1'b1);
    send_word(8'd170);
    s_valid = 1'b0;
    check("midrst_pdata", p_data, 8'd170);
    step();

    // MSB-first instance.
    check("msb_sready", s_ready_m, 1'b1);
    send_word_m(8'd170);
    step();
    send_word_m(8'd15);
    step();

    check("total_words", n_words, 9);
    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
